// File: rtl/mmu_pkg.sv
// Shared constants for the 6809 context MMU:
// I/O register slots, PTE bit positions and fault FSM states.
package mmu_pkg;

    localparam logic [3:0] SLOT_URD  = 4'h1;
    localparam logic [3:0] SLOT_UWR  = 4'h2;
    localparam logic [3:0] SLOT_CHRD = 4'h3;
    localparam logic [3:0] SLOT_CHWR = 4'h4;
    localparam logic [3:0] SLOT_ROM  = 4'h5;
    localparam logic [3:0] SLOT_USER = 4'h6;
    localparam logic [3:0] SLOT_PTE  = 4'h7;
    localparam logic [3:0] SLOT_POP  = 4'h8;
    localparam logic [3:0] SLOT_CTX  = 4'h9;
    localparam logic [3:0] SLOT_FLT  = 4'hA;

    localparam int PTE_INV = 7;
    localparam int PTE_WP  = 6;

    // Layout of the status/ctx read-back byte
    localparam int STAT_OVF     = 7;
    localparam int STAT_IDX_LSB = 4;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_PULSE = 2'd1,
        F_WAIT  = 2'd2
    } flt_state_e;

endpackage

// File: rtl/mmu_mode_stack.sv
// Kernel/user mode stack: {io_mapped, rom_mapped} entries pushed on
// the first E edge of a BS run, popped or reset via I/O writes.
module mmu_mode_stack #(
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          bs_i,
    input  logic          set_rom_i,
    input  logic          rom_val_i,
    input  logic          user_i,
    input  logic          pop_i,
    input  logic          clr_ovf_i,
    output logic          push_o,
    output logic          io_mapped_o,
    output logic          rom_mapped_o,
    output logic          ovf_o,
    output logic [IW-1:0] idx_o
);

    logic [DEPTH-1:0] io_q;
    logic [DEPTH-1:0] rom_q;
    logic [IW-1:0]    idx_q;
    logic             ovf_q;
    logic             prev_bs_q;

    assign push_o       = bs_i && !prev_bs_q;
    assign io_mapped_o  = io_q[idx_q];
    assign rom_mapped_o = rom_q[idx_q];
    assign ovf_o        = ovf_q;
    assign idx_o        = idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            io_q      <= DEPTH'(1);
            rom_q     <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            prev_bs_q <= 1'b0;
        end else begin
            prev_bs_q <= bs_i;
            if (push_o) begin
                // A full stack re-enters kernel mode in place
                if (idx_q != IW'(DEPTH - 1)) begin
                    idx_q               <= idx_q + IW'(1);
                    io_q[idx_q + IW'(1)]  <= 1'b1;
                    rom_q[idx_q + IW'(1)] <= 1'b0;
                end else begin
                    io_q[idx_q]  <= 1'b1;
                    rom_q[idx_q] <= 1'b0;
                    ovf_q        <= 1'b1;
                end
            end else if (set_rom_i) begin
                rom_q[idx_q] <= rom_val_i;
            end else if (user_i) begin
                idx_q    <= '0;
                io_q[0]  <= 1'b0;
                rom_q[0] <= 1'b0;
            end else if (pop_i && idx_q != '0) begin
                idx_q <= idx_q - IW'(1);
            end
            if (clr_ovf_i && !push_o) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmu_ctx_decode.sv
// 6809 address decoder and paged MMU with selectable page-table
// contexts, write-protect/invalid faults and register read-back.
module mmu_ctx_decode
    import mmu_pkg::*;
#(
    parameter int PAGE_BITS   = 3,
    parameter int FRAME_W     = 6,
    parameter int NCTX        = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic               i_eclk,
    input  logic               i_reset,
    input  logic               i_rw,
    input  logic [15:0]        i_addr,
    input  logic [7:0]         i_data,
    input  logic               i_bs,
    output logic [7:0]         o_data,
    output logic               o_data_oe,
    output logic               romcs_n,
    output logic               ramcs_n,
    output logic               uartrd_n,
    output logic               uartwr_n,
    output logic               chrd_n,
    output logic               chwr_n,
    output logic [FRAME_W-1:0] paddr,
    output logic               pgfault_n,
    output logic               o_kernel
);

    localparam int CW   = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int IW   = $clog2(STACK_DEPTH);
    localparam int NPTE = (1 << CW) << PAGE_BITS;

    logic          io_mapped;
    logic          rom_mapped;
    logic          push;
    logic          ovf;
    logic [IW-1:0] idx;

    logic [CW-1:0] ctx_q;
    logic [7:0]    pt_q [NPTE];
    logic [15:0]   fault_addr_q;
    logic [7:0]    fault_cause_q;
    flt_state_e    st_q, st_d;

    logic       ffxx, fexx, io_active, rom_sel;
    logic       io_we, ctx_we, pte_we;
    logic [3:0] slot;
    logic [7:0] cur_pte, rd_pte, stat;
    logic       wp, inv, detect;

    assign ffxx      = (i_addr[15:8] == 8'hFF);
    assign fexx      = (i_addr[15:8] == 8'hFE);
    assign io_active = fexx && io_mapped;
    assign slot      = i_addr[7:4];
    assign rom_sel   = ffxx || (i_addr[15] && rom_mapped && !io_active);

    assign romcs_n  = !rom_sel;
    assign ramcs_n  = !(i_eclk && !rom_sel && !io_active);
    assign uartrd_n = !(i_eclk && io_active && slot == SLOT_URD);
    assign uartwr_n = !(i_eclk && io_active && slot == SLOT_UWR);
    assign chrd_n   = !(i_eclk && io_active && slot == SLOT_CHRD);
    assign chwr_n   = !(i_eclk && io_active && slot == SLOT_CHWR);
    assign o_kernel = io_mapped;

    assign cur_pte = pt_q[{ctx_q, i_addr[15 -: PAGE_BITS]}];
    assign rd_pte  = pt_q[{ctx_q, i_addr[PAGE_BITS-1:0]}];
    assign paddr   = cur_pte[FRAME_W-1:0];

    // A BS push pre-empts every I/O register action on the same edge
    assign io_we  = io_active && !push;
    assign ctx_we = io_we && slot == SLOT_CTX && !i_rw;
    assign pte_we = io_we && slot == SLOT_PTE && !i_rw;

    mmu_mode_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk_i       (i_eclk),
        .rst_i       (i_reset),
        .bs_i        (i_bs),
        .set_rom_i   (io_we && slot == SLOT_ROM),
        .rom_val_i   (i_addr[0]),
        .user_i      (io_we && slot == SLOT_USER),
        .pop_i       (io_we && slot == SLOT_POP),
        .clr_ovf_i   (ctx_we),
        .push_o      (push),
        .io_mapped_o (io_mapped),
        .rom_mapped_o(rom_mapped),
        .ovf_o       (ovf),
        .idx_o       (idx)
    );

    always_ff @(posedge i_eclk) begin
        if (pte_we) begin
            pt_q[{ctx_q, i_addr[PAGE_BITS-1:0]}] <= i_data;
        end
    end

    always_comb begin
        stat                      = '0;
        stat[STAT_OVF]            = ovf;
        stat[STAT_IDX_LSB +: IW]  = idx;
        stat[CW-1:0]              = ctx_q;
    end

    always_comb begin
        o_data = '0;
        unique case (1'b1)
            slot == SLOT_PTE: o_data = rd_pte;
            slot == SLOT_CTX: o_data = stat;
            slot == SLOT_FLT && i_addr[1:0] == 2'd0:
                o_data = fault_addr_q[15:8];
            slot == SLOT_FLT && i_addr[1:0] == 2'd1:
                o_data = fault_addr_q[7:0];
            slot == SLOT_FLT && i_addr[1:0] == 2'd2:
                o_data = fault_cause_q;
            default: o_data = '0;
        endcase
    end

    assign o_data_oe = i_eclk && i_rw && io_active &&
        (slot == SLOT_PTE || slot == SLOT_CTX || slot == SLOT_FLT);

    assign wp     = cur_pte[PTE_WP] && !i_rw;
    assign inv    = cur_pte[PTE_INV];
    assign detect = !io_mapped && (inv || wp) && st_q == F_IDLE;

    always_comb begin
        st_d      = st_q;
        pgfault_n = 1'b1;
        case (st_q)
            F_IDLE:  if (detect) st_d = F_PULSE;
            F_PULSE: begin
                st_d      = F_WAIT;
                pgfault_n = 1'b0;
            end
            F_WAIT:  if (io_mapped) st_d = F_IDLE;
            default: st_d = F_IDLE;
        endcase
    end

    always_ff @(posedge i_eclk or posedge i_reset) begin
        if (i_reset) begin
            st_q          <= F_IDLE;
            ctx_q         <= '0;
            fault_addr_q  <= '0;
            fault_cause_q <= '0;
        end else begin
            st_q <= st_d;
            if (ctx_we) begin
                ctx_q <= (NCTX > 1) ? i_data[CW-1:0] : '0;
            end
            if (detect) begin
                fault_addr_q  <= i_addr;
                fault_cause_q <= 8'({ctx_q, wp, inv});
            end
        end
    end

endmodule

// File: tb/tb_mmu_ctx_decode.sv
// Scoreboard bench for mmu_ctx_decode: directed bus cycles push
// expectations, a monitor checks them while E is high.
module tb_mmu_ctx_decode;

    logic        clk;
    logic        i_reset, i_rw, i_bs;
    logic [15:0] i_addr;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_data_oe, romcs_n, ramcs_n;
    logic        uartrd_n, uartwr_n, chrd_n, chwr_n;
    logic [5:0]  paddr;
    logic        pgfault_n, o_kernel;

    mmu_ctx_decode dut (
        .i_eclk   (clk),
        .i_reset  (i_reset),
        .i_rw     (i_rw),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_bs     (i_bs),
        .o_data   (o_data),
        .o_data_oe(o_data_oe),
        .romcs_n  (romcs_n),
        .ramcs_n  (ramcs_n),
        .uartrd_n (uartrd_n),
        .uartwr_n (uartwr_n),
        .chrd_n   (chrd_n),
        .chwr_n   (chwr_n),
        .paddr    (paddr),
        .pgfault_n(pgfault_n),
        .o_kernel (o_kernel)
    );

    typedef enum int {
        K_DATA, K_OE, K_ROMCS, K_RAMCS,
        K_PGF, K_KERN, K_PADDR, K_URD
    } kind_e;

    typedef struct {
        int         cyc;
        kind_e      kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t em;
    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic bus(input logic rw, input logic [15:0] a,
                       input logic [7:0] d = 8'h00,
                       input logic bs = 1'b0);
        @(negedge clk);
        i_rw   = rw;
        i_addr = a;
        i_data = d;
        i_bs   = bs;
    endtask

    task automatic want(input kind_e k, input logic [7:0] v,
                        input string n);
        exp_t e;
        e.cyc  = cyc + 1;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic check_one(input exp_t e);
        logic [7:0] act;
        logic       ok;
        case (e.kind)
            K_DATA:  act = o_data;
            K_OE:    act = {7'd0, o_data_oe};
            K_ROMCS: act = {7'd0, romcs_n};
            K_RAMCS: act = {7'd0, ramcs_n};
            K_PGF:   act = {7'd0, pgfault_n};
            K_KERN:  act = {7'd0, o_kernel};
            K_PADDR: act = {2'd0, paddr};
            default: act = {7'd0, uartrd_n};
        endcase
        ok = (act == e.exp) && (e.cyc == cyc);
        if (e.kind == K_DATA && !o_data_oe) ok = 1'b0;
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %02h (oe=%0b cyc=%0d) want %02h (cyc=%0d)",
                     e.name, act, o_data_oe, cyc, e.exp, e.cyc);
        end
    endtask

    always @(posedge clk) begin
        #3;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            em = sb.pop_front();
            check_one(em);
        end
    end

    task automatic chk(input string n, input logic a, input logic w);
        nchk++;
        if (a !== w) begin
            nerr++;
            $display("FAIL %s: got %0b want %0b", n, a, w);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 i_reset = 1'b1;
        #1;
        chk("rst_async_pgf", pgfault_n, 1'b1);
        chk("rst_async_kern", o_kernel, 1'b1);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0;
        i_rw    = 1'b1;
        i_addr  = 16'hFF00;
        i_data  = 8'h00;
        i_bs    = 1'b0;
        #12 i_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;

        // Reset state
        bus(1, 16'hFF00);
        want(K_ROMCS, 8'h00, "rst_romcs");
        want(K_KERN, 8'h01, "rst_kernel");
        want(K_PGF, 8'h01, "rst_pgf");
        bus(1, 16'h8000);
        want(K_RAMCS, 8'h00, "rst_ramcs");
        want(K_ROMCS, 8'h01, "rst_romcs_8000");
        want(K_OE, 8'h00, "rst_oe");
        bus(1, 16'hFE90);
        want(K_DATA, 8'h00, "rst_status");
        bus(1, 16'hFE10);
        want(K_URD, 8'h00, "uart_rd");
        want(K_RAMCS, 8'h01, "io_no_ram");

        // Fill every context: PTE k of ctx c = frame c*8+k
        for (int c = 0; c < 4; c++) begin
            bus(0, 16'hFE90, 8'(c));
            for (int k = 0; k < 8; k++)
                bus(0, 16'hFE70 + 16'(k), 8'(c * 8 + k));
        end
        bus(0, 16'hFE90, 8'h00);
        bus(1, 16'hFE73);
        want(K_DATA, 8'h03, "pte_readback");

        // Context switch
        bus(0, 16'hFE90, 8'h01);
        bus(0, 16'hFE74, 8'h15);
        bus(0, 16'hFE60);
        bus(1, 16'h8000);
        want(K_PADDR, 8'h15, "ctx1_paddr");
        want(K_KERN, 8'h00, "user_mode");
        want(K_RAMCS, 8'h00, "user_ramcs");
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        want(K_KERN, 8'h01, "bs_kernel");
        bus(0, 16'hFE90, 8'h00);
        bus(1, 16'h8000);
        want(K_PADDR, 8'h04, "ctx0_paddr");

        // Write-protect fault
        bus(0, 16'hFE72, 8'h43);
        bus(0, 16'hFE60);
        bus(0, 16'h4123, 8'hAA);
        want(K_PGF, 8'h00, "wp_pulse");
        want(K_PADDR, 8'h03, "wp_paddr");
        bus(1, 16'h8000);
        want(K_PGF, 8'h01, "wp_pulse_end");
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        want(K_KERN, 8'h01, "wp_kernel");
        bus(1, 16'hFEA0);
        want(K_DATA, 8'h41, "wp_fa_hi");
        bus(1, 16'hFEA1);
        want(K_DATA, 8'h23, "wp_fa_lo");
        bus(1, 16'hFEA2);
        want(K_DATA, 8'h02, "wp_cause");

        // Invalid-page read fault; repeats ignored until kernel
        bus(0, 16'hFE72, 8'h83);
        bus(0, 16'hFE60);
        bus(1, 16'h4000);
        want(K_PGF, 8'h00, "inv_pulse");
        bus(1, 16'h4010);
        want(K_PGF, 8'h01, "inv_no_pulse1");
        bus(1, 16'h4020);
        want(K_PGF, 8'h01, "inv_no_pulse2");
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        want(K_KERN, 8'h01, "inv_kernel");
        bus(1, 16'hFEA1);
        want(K_DATA, 8'h00, "inv_fa_lo");
        bus(1, 16'hFEA0);
        want(K_DATA, 8'h40, "inv_fa_hi");
        bus(1, 16'hFEA2);
        want(K_DATA, 8'h01, "inv_cause");

        // Async reset during a fault pulse
        bus(0, 16'hFE90, 8'h02);
        bus(0, 16'hFE72, 8'h83);
        bus(0, 16'hFE60);
        bus(1, 16'h4000);
        want(K_PGF, 8'h00, "ctx2_pulse");
        do_reset();
        bus(1, 16'hFE90);
        want(K_DATA, 8'h00, "rst2_status");
        bus(1, 16'hFEA0);
        want(K_DATA, 8'h00, "rst2_fa_hi");
        bus(1, 16'hFEA2);
        want(K_DATA, 8'h00, "rst2_cause");
        bus(1, 16'hFE72);
        want(K_DATA, 8'h83, "pte_kept");

        // Overflow: five pushes with depth 4
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        bus(1, 16'hFE90);
        want(K_DATA, 8'h10, "idx1");
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        bus(1, 16'hFE90);
        want(K_DATA, 8'h20, "idx2");
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        bus(1, 16'hFE90);
        want(K_DATA, 8'h30, "idx3");
        bus(0, 16'hFE51);
        bus(1, 16'h8000);
        want(K_ROMCS, 8'h00, "rom_mapped3");
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        bus(1, 16'h8000);
        want(K_ROMCS, 8'h01, "ovf_entry_reset");
        bus(1, 16'hFE90);
        want(K_DATA, 8'hB0, "ovf_idx3");
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        bus(1, 16'hFE90);
        want(K_DATA, 8'hB0, "ovf_hold");

        // Underflow: five pops
        for (int i = 0; i < 5; i++) bus(0, 16'hFE80);
        bus(1, 16'hFE90);
        want(K_DATA, 8'h80, "pop_sat");
        bus(0, 16'hFE90, 8'h00);
        bus(1, 16'hFE90);
        want(K_DATA, 8'h00, "ovf_clear");

        // BS push beats a simultaneous $FE50 write
        bus(0, 16'hFE51);
        bus(1, 16'h8000);
        want(K_ROMCS, 8'h00, "rom0_set");
        bus(0, 16'hFE50, 8'h00, 1'b1);
        want(K_KERN, 8'h01, "sim_kernel");
        bus(1, 16'h8000);
        want(K_ROMCS, 8'h01, "sim_new_entry");
        bus(1, 16'hFE90);
        want(K_DATA, 8'h10, "sim_idx");
        bus(0, 16'hFE80);
        bus(1, 16'h8000);
        want(K_ROMCS, 8'h00, "sim_entry0_kept");

        // BS held high pushes only once
        bus(1, 16'hFFFE, 8'h00, 1'b1);
        bus(1, 16'hFFFF, 8'h00, 1'b1);
        bus(1, 16'hFE90);
        want(K_DATA, 8'h10, "bs_held_once");

        repeat (2) @(posedge clk);
        #5;
        nchk++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
